muldiv_sequencer: RTL
=====================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request from EX stage; qualifies funct3/op_a/op_b.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op_a  input  XLEN  rs1 value (multiplicand/dividend).
REQ-007 op_b  input  XLEN  rs2 value (multiplier/divisor).
REQ-008 flush  input  1  pipeline flush; aborts the operation in flight.
REQ-009 busy  output  1  high in CALC and DONE states.
REQ-010 done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-011 result  output  XLEN  registered result.
REQ-012 stall  output  1  combinational: start & ~done; holds the upstream pipeline.

Function
REQ-013 FSM states IDLE, CALC, DONE; IDLE->CALC on start & ~flush; CALC->DONE when iteration count reaches 31; DONE->IDLE unconditionally.
REQ-014 In IDLE with start: latch funct3, operand magnitudes, and the result-sign and remainder-sign flags, and clear the 6-bit counter.
REQ-015 CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle; exactly 32 CALC cycles.
REQ-016 Latency: start sampled at edge N; done=1 during the cycle following edge N+33; a back-to-back start is accepted in the done cycle.
REQ-017 Signedness: MUL/MULH/DIV/REM both operands signed; MULHSU op_a signed, op_b unsigned; MULHU/DIVU/REMU unsigned.
REQ-018 MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32] of the correctly signed 64-bit product.
REQ-019 Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a); final negation is applied on the DONE transition.
REQ-020 Divide by zero: quotient 0xFFFFFFFF; remainder = op_a.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000; remainder 0.
REQ-022 start while busy is ignored; operands are not re-latched.
REQ-023 flush in CALC or DONE: IDLE on next edge, done suppressed, result unchanged.
REQ-024 flush together with start in IDLE: flush wins, state stays IDLE.
REQ-025 result holds its last value until the next done.

Reset
REQ-026 On rst_n low: state IDLE, busy 0, done 0, result 0, counter 0, all latched operands 0.
REQ-027 Reset asserted mid-operation aborts immediately; no done pulse follows deassertion.

Configuration
REQ-028 Macro MULDIV_EARLY_OUT_EN defined: divide by zero, signed overflow, and either multiply operand zero go IDLE->DONE directly, so done is asserted one cycle after start.
REQ-029 Macro MULDIV_EARLY_OUT_EN undefined: these cases run the full 32 CALC cycles; results are identical to REQ-018 to REQ-021.

Structure
REQ-030 Package muldiv_pkg holds XLEN, the funct3 encodings as named constants, the state enum type, and the counter width.
REQ-031 One sub-module, muldiv_negate: combinational conditional two's-complement used for operand magnitudes and final sign fix.

Verification
REQ-032 MUL 7 * -3 -> result 0xFFFFFFEB; done exactly 33 cycles after start; stall high until done.
REQ-033 MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1 * 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-035 DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; REM -> 0; done latency 1 cycle with macro, 33 cycles without.
REQ-036 flush at CALC cycle 10 -> no done, busy low next cycle, result keeps previous value; new start then completes normally.
REQ-037 rst_n low at CALC cycle 5 -> all outputs 0 immediately; start while busy ignored (the first operation's result is delivered).

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;

    // Iteration index of the final CALC step.
    localparam logic [CNT_W-1:0] CNT_LAST = 6'd31;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement: y = neg ? -a : a.
module muldiv_negate #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic         neg_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring
// shift-subtract steps on operand magnitudes, sign fix on the way out.
// Optional macro MULDIV_EARLY_OUT_EN: divide by zero, signed overflow and
// zero multiply operands skip CALC and finish one cycle after start.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; operands latched on acceptance
// CALC    | one iteration per cycle, cnt_q = 0..31
// DONE    | sign fix applied; result/done registered on the exit edge
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            stall
);

    state_e            state_q;
    logic [2:0]        f3_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   mag_a_q, mag_b_q;
    logic [XLEN-1:0]   hi_q, lo_q;
    logic              qsign_q, rsign_q;
    logic              busy_q, done_q;
    logic [XLEN-1:0]   result_q;

    logic              is_div_in, a_signed, b_signed, sign_a, sign_b;
    logic              b_zero, qsign_in, early_out;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   hi_init, lo_init;
    logic [XLEN:0]     mul_sum, div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   hi_d, lo_d;
    logic [2*XLEN-1:0] fix_in, fix_out;
    logic              fix_neg;
    logic [XLEN-1:0]   res_sel;

    assign is_div_in = funct3[2];
    assign a_signed  = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
    assign b_signed  = a_signed && (funct3 != F3_MULHSU);
    assign sign_a    = a_signed & op_a[XLEN-1];
    assign sign_b    = b_signed & op_b[XLEN-1];
    assign b_zero    = (op_b == '0);
    // A zero divisor returns all ones regardless of the dividend's sign.
    assign qsign_in  = (sign_a ^ sign_b) & ~(is_div_in & b_zero);

    muldiv_negate #(.W(XLEN)) u_neg_a (.a_i(op_a), .neg_i(sign_a), .y_o(mag_a));
    muldiv_negate #(.W(XLEN)) u_neg_b (.a_i(op_b), .neg_i(sign_b), .y_o(mag_b));

`ifdef MULDIV_EARLY_OUT_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    logic a_zero, div_ovf;
    assign a_zero    = (op_a == '0);
    assign div_ovf   = sign_a & sign_b & (op_a == MIN_NEG) & (op_b == '1);
    assign early_out = is_div_in ? (b_zero | div_ovf) : (a_zero | b_zero);
`else
    assign early_out = 1'b0;
`endif

    // Datapath preload; early-out cases load the final iteration values directly.
    always_comb begin
        hi_init = '0;
        lo_init = is_div_in ? mag_a : mag_b;
        if (early_out) begin
            if (is_div_in && b_zero) begin
                hi_init = mag_a;
                lo_init = '1;
            end else if (!is_div_in) begin
                lo_init = '0;
            end
        end
    end

    // One multiply (shift-add right) or divide (restoring shift-subtract) step.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, mag_b_q});
        if (f3_q[2]) begin
            hi_d = div_ge ? (div_shift[XLEN-1:0] - mag_b_q) : div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Choose what gets sign-fixed: full product, quotient, or remainder.
    always_comb begin
        fix_in  = {hi_q, lo_q};
        fix_neg = qsign_q;
        case (f3_q)
            F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU: fix_in = {hi_q, lo_q};
            F3_DIV, F3_DIVU:                      fix_in = {{XLEN{1'b0}}, lo_q};
            F3_REM, F3_REMU: begin
                fix_in  = {{XLEN{1'b0}}, hi_q};
                fix_neg = rsign_q;
            end
            default: ;
        endcase
    end

    muldiv_negate #(.W(2*XLEN)) u_neg_fix (.a_i(fix_in), .neg_i(fix_neg), .y_o(fix_out));

    // Upper product half for MULH*, low word otherwise.
    always_comb begin
        res_sel = fix_out[XLEN-1:0];
        case (f3_q)
            F3_MULH, F3_MULHSU, F3_MULHU: res_sel = fix_out[2*XLEN-1:XLEN];
            default: ;
        endcase
    end

    // Sequencer FSM with registered busy/done/result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            f3_q     <= '0;
            cnt_q    <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !flush) begin
                        f3_q    <= funct3;
                        mag_a_q <= mag_a;
                        mag_b_q <= mag_b;
                        hi_q    <= hi_init;
                        lo_q    <= lo_init;
                        qsign_q <= qsign_in;
                        rsign_q <= sign_a;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= early_out ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        hi_q  <= hi_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                    if (!flush) begin
                        result_q <= res_sel;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign stall  = start & ~done_q;

endmodule
